// File: rtl/data_out_transmitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_out_transmitter_if : bus/control bundle for the I2C read-data    |
// | transmitter (SCL/SDA samples, enable, payload, status). Rev 1.0       |
// +----------------------------------------------------------------------+
interface data_out_transmitter_if #(
  parameter int NUM_BYTES = 6
) ();
  localparam int c_cnt_w = $clog2(NUM_BYTES + 1);

  logic                      SCL;
  logic                      SCL_prev;
  logic                      SDA;
  logic                      SDA_prev;
  logic                      enable;
  logic [NUM_BYTES-1:0][7:0] tx_data;
  logic                      SDA_down;
  logic                      done;
  logic                      nack_received;
  logic                      aborted;
  logic [c_cnt_w-1:0]        bytes_sent;

  modport master (
    output SCL, SCL_prev, SDA, SDA_prev, enable, tx_data,
    input  SDA_down, done, nack_received, aborted, bytes_sent
  );

  modport slave (
    input  SCL, SCL_prev, SDA, SDA_prev, enable, tx_data,
    output SDA_down, done, nack_received, aborted, bytes_sent
  );
endinterface
`default_nettype wire

// File: rtl/data_out_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_out_transmitter : I2C slave read-data shifter with ACK sampling. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module data_out_transmitter #(
  parameter int NUM_BYTES = 6
) (
  input  logic                 FPGA_clk,
  input  logic                 rst,
  data_out_transmitter_if.slave bus
);
  localparam int                  c_cnt_w     = $clog2(NUM_BYTES + 1);
  localparam logic [c_cnt_w-1:0]  c_num_bytes = c_cnt_w'(NUM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [NUM_BYTES-1:0][7:0] r_buf;
  logic [7:0]                r_shift;
  logic [7:0]                w_next_byte;
  logic [2:0]                r_bit_cnt;
  logic                      r_ack_bit;
  logic                      r_drive;
  logic                      r_nack;
  logic                      r_aborted;
  logic [c_cnt_w-1:0]        r_bytes_sent;

  logic w_fall, w_rise, w_bus_cond;
  logic w_drive_nxt, w_load_first, w_load_next, w_shift, w_sample;
  logic w_set_nack, w_set_abort, w_clear;

  assign w_fall     = bus.SCL_prev & ~bus.SCL;
  assign w_rise     = ~bus.SCL_prev & bus.SCL;
  assign w_bus_cond = bus.SCL & bus.SCL_prev & (bus.SDA ^ bus.SDA_prev);

  // bytes_sent already points at the next byte once its predecessor's ACK rose
  always_comb begin
    w_next_byte = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (r_bytes_sent == c_cnt_w'(i)) w_next_byte = r_buf[i];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drive_nxt  = 1'b0;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    w_shift      = 1'b0;
    w_sample     = 1'b0;
    w_set_nack   = 1'b0;
    w_set_abort  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_load_first = 1'b1;
          w_state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.enable) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_bus_cond && !r_drive) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_fall) begin
          if (r_bit_cnt != 3'd0) begin
            w_shift     = 1'b1;
            w_drive_nxt = ~r_shift[6];
          end else begin
            w_state_nxt = S_ACK;
          end
        end else begin
          w_drive_nxt = ~r_shift[7];
        end
      end
      S_ACK: begin
        if (!bus.enable) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_bus_cond) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_rise) begin
          w_sample = 1'b1;
        end else if (w_fall) begin
          if (r_ack_bit) begin
            w_set_nack  = (r_bytes_sent < c_num_bytes);
            w_state_nxt = S_DONE;
          end else if (r_bytes_sent < c_num_bytes) begin
            w_load_next = 1'b1;
            w_drive_nxt = ~w_next_byte[7];
            w_state_nxt = S_SEND;
          end else begin
            // master over-read: stay released for the rest of the transfer
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!bus.enable) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      r_buf        <= '0;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_ack_bit    <= 1'b0;
      r_drive      <= 1'b0;
      r_nack       <= 1'b0;
      r_aborted    <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      r_drive <= w_drive_nxt;
      if (w_load_first) begin
        r_buf        <= bus.tx_data;
        r_shift      <= bus.tx_data[0];
        r_bit_cnt    <= 3'd7;
        r_ack_bit    <= 1'b0;
        r_nack       <= 1'b0;
        r_aborted    <= 1'b0;
        r_bytes_sent <= '0;
      end
      if (w_shift) begin
        r_shift   <= {r_shift[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - 3'd1;
      end
      if (w_load_next) begin
        r_shift   <= w_next_byte;
        r_bit_cnt <= 3'd7;
      end
      if (w_sample) begin
        r_ack_bit    <= bus.SDA;
        r_bytes_sent <= r_bytes_sent + 1'b1;
      end
      if (w_set_nack)  r_nack    <= 1'b1;
      if (w_set_abort) r_aborted <= 1'b1;
      if (w_clear) begin
        r_ack_bit    <= 1'b0;
        r_nack       <= 1'b0;
        r_aborted    <= 1'b0;
        r_bytes_sent <= '0;
      end
    end
  end

  // gate with rst so the pad is released the instant reset asserts
  assign bus.SDA_down      = r_drive & ~rst;
  assign bus.done          = (r_state == S_DONE);
  assign bus.nack_received = r_nack;
  assign bus.aborted       = r_aborted;
  assign bus.bytes_sent    = r_bytes_sent;
endmodule
`default_nettype wire

// File: tb/tb_data_out_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_out_transmitter : bit-level I2C master model driving two      |
// | transmitters (NUM_BYTES=2 and NUM_BYTES=1). Rev 1.0                   |
// +----------------------------------------------------------------------+
module tb_data_out_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b0, scl_prev = 1'b0, sda = 1'b1, sda_prev = 1'b1, msda = 1'b1;
  logic en1 = 1'b0, en2 = 1'b0;
  logic [0:0][7:0] tx1 = '0;
  logic [1:0][7:0] tx2 = '0;

  int   n_checks = 0, n_fail = 0;
  bit   timing_on = 1'b1;
  int   since_en = 100;
  logic last_drv = 1'b0;
  int   drv_cnt = 0;
  logic [7:0] obs [3];
  int   n_obs = 0;

  always #5 clk = ~clk;

  data_out_transmitter_if #(.NUM_BYTES(1)) if1 ();
  data_out_transmitter_if #(.NUM_BYTES(2)) if2 ();

  assign if1.SCL = scl;  assign if1.SCL_prev = scl_prev;
  assign if1.SDA = sda;  assign if1.SDA_prev = sda_prev;
  assign if1.enable = en1; assign if1.tx_data = tx1;
  assign if2.SCL = scl;  assign if2.SCL_prev = scl_prev;
  assign if2.SDA = sda;  assign if2.SDA_prev = sda_prev;
  assign if2.enable = en2; assign if2.tx_data = tx2;

  data_out_transmitter #(.NUM_BYTES(1)) dut1 (.FPGA_clk(clk), .rst(rst), .bus(if1.slave));
  data_out_transmitter #(.NUM_BYTES(2)) dut2 (.FPGA_clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {done, nack_received, aborted, SDA_down, bytes_sent[3:0]}
  function automatic logic [7:0] outs(input int sel);
    if (sel == 1)
      return {if1.done, if1.nack_received, if1.aborted, if1.SDA_down, 4'(if1.bytes_sent)};
    return {if2.done, if2.nack_received, if2.aborted, if2.SDA_down, 4'(if2.bytes_sent)};
  endfunction

  // One FPGA_clk: observe outputs of the edge just passed, then apply new bus samples.
  task automatic step(input logic scl_v);
    logic d;
    @(negedge clk);
    d = if1.SDA_down | if2.SDA_down;
    if (timing_on && d !== last_drv) begin
      n_checks++;
      if (!(scl_prev && !scl) && since_en != 1) begin
        n_fail++;
        $display("FAIL sda_timing: SDA_down %0b->%0b, required only one clk after SCL fall (scl=%0b prev=%0b t=%0t)",
                 last_drv, d, scl, scl_prev, $time);
      end
    end
    if (d) drv_cnt++;
    last_drv = d;
    since_en++;
    scl_prev = scl;
    scl      = scl_v;
    sda_prev = sda;
    sda      = msda & ~d;
  endtask

  task automatic byte_read(input int lo, input int hi, output logic [7:0] v);
    msda = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      repeat (lo) step(1'b0);
      repeat (hi) step(1'b1);
      v[k] = sda;
    end
  endtask

  task automatic ack_slot(input bit nack, input bit stop, input int lo, input int hi);
    msda = nack;
    repeat (lo) step(1'b0);
    step(1'b1);
    if (stop) msda = 1'b1;
    repeat (hi - 1) step(1'b1);
  endtask

  task automatic run_xfer(input int sel, input logic [7:0] b0, input logic [7:0] b1,
                          input int n_acks, input int abort_byte, input int lo, input int hi,
                          input bit scramble);
    msda = 1'b1; drv_cnt = 0; n_obs = 0;
    if (sel == 1) begin tx1[0] = b0; en1 = 1'b1; end
    else begin tx2[0] = b0; tx2[1] = b1; en2 = 1'b1; end
    since_en = 0;
    repeat (3) step(1'b0);
    if (scramble) begin tx1 = 8'($urandom); tx2 = 16'($urandom); end
    for (int i = 0; i <= n_acks; i++) begin
      byte_read(lo, hi, obs[i]);
      n_obs = i + 1;
      if (i == abort_byte) begin ack_slot(1'b0, 1'b1, lo, hi); break; end
      ack_slot(i == n_acks, 1'b0, lo, hi);
    end
    msda = 1'b1;
    repeat (3) step(1'b0);
  endtask

  task automatic check_xfer(input string tag, input int sel, input logic [7:0] e [3],
                            input int sent, input bit nack, input bit ab);
    logic [7:0] o;
    for (int k = 0; k < n_obs; k++) chk($sformatf("%s byte%0d", tag, k), 32'(obs[k]), 32'(e[k]));
    o = outs(sel);
    chk({tag, " done"}, 32'(o[7]), 32'd1);
    chk({tag, " nack_received"}, 32'(o[6]), 32'(nack));
    chk({tag, " aborted"}, 32'(o[5]), 32'(ab));
    chk({tag, " SDA_down"}, 32'(o[4]), 32'd0);
    chk({tag, " bytes_sent"}, 32'(o[3:0]), 32'(sent));
  endtask

  task automatic end_xfer(input string tag, input int sel);
    logic [7:0] o;
    en1 = 1'b0; en2 = 1'b0;
    repeat (2) step(1'b0);
    o = outs(sel);
    chk({tag, " idle outputs"}, 32'(o), 32'd0);
  endtask

  // Reference: what the master observes and the final status, from the protocol rules.
  task automatic model(input int n, input logic [7:0] b0, input logic [7:0] b1,
                       input int n_acks, input int abort_byte,
                       output logic [7:0] e [3], output int sent, output bit nack, output bit ab);
    logic [7:0] bs [2];
    bit released;
    bs[0] = b0; bs[1] = b1;
    sent = 0; nack = 1'b0; ab = 1'b0; released = 1'b0;
    e[0] = 8'h00; e[1] = 8'h00; e[2] = 8'h00;
    for (int i = 0; i <= n_acks; i++) begin
      e[i] = released ? 8'hFF : bs[i];
      if (!released) sent = i + 1;
      if (i == abort_byte) begin ab = !released; break; end
      if (i == n_acks) begin nack = !released && (sent < n); break; end
      if (sent == n) released = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] b0, b1;
    int         n_acks, abort_byte;
    logic [7:0] e0, e1, e2;
    int         sent;
    bit         nack, ab;
  } vec_t;

  initial begin
    vec_t       vecs [6];
    logic [7:0] e [3];
    logic [7:0] o;
    int sent, sel, n, na, abt, lo, hi;
    bit nack, ab;
    logic [7:0] b0, b1;

    vecs[0] = '{8'hA5, 8'h3C, 1, -1, 8'hA5, 8'h3C, 8'h00, 2, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 8'h55, 0, -1, 8'h80, 8'h00, 8'h00, 1, 1'b1, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 2, -1, 8'h12, 8'h34, 8'hFF, 2, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 8'hC3, 0,  0, 8'h5A, 8'h00, 8'h00, 1, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'hFF, 1,  1, 8'h00, 8'hFF, 8'h00, 2, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 8'h80, 1, -1, 8'h01, 8'h80, 8'h00, 2, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset dut1 outputs", 32'(outs(1)), 32'd0);
    chk("reset dut2 outputs", 32'(outs(2)), 32'd0);
    rst = 1'b0;
    repeat (2) step(1'b0);

    for (int v = 0; v < 6; v++) begin
      run_xfer(2, vecs[v].b0, vecs[v].b1, vecs[v].n_acks, vecs[v].abort_byte, 4, 4, v[0]);
      e[0] = vecs[v].e0; e[1] = vecs[v].e1; e[2] = vecs[v].e2;
      check_xfer($sformatf("vec%0d", v), 2, e, vecs[v].sent, vecs[v].nack, vecs[v].ab);
      end_xfer($sformatf("vec%0d", v), 2);
    end

    // Single-byte device, master ACKs the only byte and clocks one more
    run_xfer(1, 8'hFF, 8'h00, 1, -1, 3, 3, 1'b1);
    e[0] = 8'hFF; e[1] = 8'hFF; e[2] = 8'h00;
    check_xfer("overread", 1, e, 1, 1'b0, 1'b0);
    chk("overread drive cycles", 32'(drv_cnt), 32'd0);
    end_xfer("overread", 1);

    // Enable dropped after bit 4 of 0x00
    tx2[0] = 8'h00; en2 = 1'b1; since_en = 0; msda = 1'b1;
    repeat (3) step(1'b0);
    repeat (4) begin repeat (4) step(1'b0); repeat (4) step(1'b1); end
    step(1'b0); step(1'b0);
    o = outs(2);
    chk("endrop SDA_down before", 32'(o[4]), 32'd1);
    timing_on = 1'b0; en2 = 1'b0;
    step(1'b0);
    o = outs(2);
    chk("endrop SDA_down after", 32'(o[4]), 32'd0);
    chk("endrop done", 32'(o[7]), 32'd0);
    repeat (3) step(1'b0);
    o = outs(2);
    chk("endrop idle outputs", 32'(o), 32'd0);
    timing_on = 1'b1;

    // Asynchronous reset mid-byte
    tx2[0] = 8'h00; en2 = 1'b1; since_en = 0;
    repeat (3) step(1'b0);
    repeat (4) step(1'b0);
    repeat (2) step(1'b1);
    o = outs(2);
    chk("rst pre SDA_down", 32'(o[4]), 32'd1);
    timing_on = 1'b0;
    #2 rst = 1'b1;
    #1 o = outs(2);
    chk("rst async outputs", 32'(o), 32'd0);
    en2 = 1'b0;
    repeat (2) step(1'b0);
    rst = 1'b0;
    repeat (2) step(1'b0);
    timing_on = 1'b1;

    // Randomised transfers against the reference model
    for (int t = 0; t < 24; t++) begin
      sel = ($urandom % 2 == 0) ? 1 : 2;
      n   = (sel == 1) ? 1 : 2;
      b0  = 8'($urandom);
      b1  = 8'($urandom);
      na  = int'($urandom % 32'(n + 1));
      abt = ($urandom % 4 == 0) ? int'($urandom % 32'(na + 1)) : -1;
      lo  = 2 + int'($urandom % 4);
      hi  = 2 + int'($urandom % 4);
      model(n, b0, b1, na, abt, e, sent, nack, ab);
      run_xfer(sel, b0, b1, na, abt, lo, hi, 1'b1);
      check_xfer($sformatf("rnd%0d", t), sel, e, sent, nack, ab);
      end_xfer($sformatf("rnd%0d", t), sel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/data_out_transmitter.md
Name: data_out_transmitter

Overview:
- Slave-side transmitter for I2C read transfers; the counterpart of the data-in receiver.
- Takes control of SDA after the address phase has ACKed a read (R/W=1).
- Shifts out up to NUM_BYTES bytes MSB-first, releases SDA in each ACK slot and samples the master's ACK/NACK.
- Sits beside the data-in block under the slave top level and shares the upstream SCL/SDA synchroniser; the top level ORs the two SDA_down outputs into the open-drain pad.

Parameters:
- NUM_BYTES, 6, number of bytes available to send per read transaction (>=1)

Ports:
- FPGA_clk  input  1  system clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- SCL  input  1  synchronised SCL, current sample
- SCL_prev  input  1  SCL sample from previous FPGA_clk cycle
- SDA  input  1  synchronised SDA, current sample
- SDA_prev  input  1  SDA sample from previous FPGA_clk cycle
- enable  input  1  level; high from the falling SCL edge ending the address ACK slot until end of transaction
- tx_data  input  NUM_BYTES x 8  bytes to send; index 0 is sent first
- SDA_down  output  1  1 = pull SDA low; 0 = release
- done  output  1  level; high while in DONE
- nack_received  output  1  master NACKed before all bytes were sent; valid while done=1
- aborted  output  1  START/STOP seen mid-transfer; valid while done=1
- bytes_sent  output  $clog2(NUM_BYTES+1)  count of bytes whose ACK slot has completed

Behaviour:
- Edge and condition definitions:
  - SCL fall = SCL_prev & ~SCL.
  - SCL rise = ~SCL_prev & SCL.
  - bus condition (START/STOP) = SCL & SCL_prev & (SDA != SDA_prev).
- Reset (async, rst=1): state IDLE; SDA_down, done, nack_received, aborted, bytes_sent all 0; shift register and counters 0.
- State machine:
  - IDLE: on enable=1, latch tx_data into internal buffer, load byte 0 into the shift register, bit counter=7 -> SEND. SDA_down = ~shift[7] from the next cycle, i.e. one FPGA_clk after entry while SCL is still low.
  - SEND: SDA_down = ~shift[7]. On SCL fall:
    - bit counter != 0: shift left, decrement.
    - bit counter = 0: SDA_down -> 0, go to ACK.
  - ACK: SDA_down = 0. On SCL rise:
    - sample SDA into ack_bit.
    - increment bytes_sent.
  - ACK, on the following SCL fall:
    - ack_bit=1 (NACK) and bytes_sent < NUM_BYTES: nack_received=1 -> DONE.
    - ack_bit=1 and bytes_sent = NUM_BYTES: normal end -> DONE.
    - ack_bit=0 and bytes_sent < NUM_BYTES: load next byte, bit counter=7 -> SEND.
    - ack_bit=0 and bytes_sent = NUM_BYTES: master over-read. Stay released (never drive further bits) -> DONE.
  - DONE: done=1, SDA_down=0, flags held. enable=0 -> IDLE, clearing done, flags and bytes_sent.
- SDA only changes while SCL is low. SDA_down updates one FPGA_clk after an SCL fall, never on an SCL rise.
- Bus condition in SEND or ACK:
  - Acted on only when SDA_down=0 (in SEND, a change caused by the slave's own drive cannot occur while SCL is high).
  - Effect: SDA_down=0, aborted=1 -> DONE.
- enable falling in SEND or ACK: next cycle SDA_down=0, state IDLE, no done.
- SCL fall and bus condition in the same cycle cannot coincide by definition; SCL rise in SEND is ignored.
- tx_data changes after the IDLE latch have no effect until the next transaction.
- Reset mid-byte: SDA released asynchronously (SDA_down combinationally 0 while rst=1).

Test Plan:
- NUM_BYTES=2, tx_data={0xA5,0x3C}, master ACK then NACK -> SDA bus shows 1010_0101, released, 0011_1100, released; done=1, nack_received=0, aborted=0, bytes_sent=2.
- tx_data[0]=0x80, master NACKs after byte 0 -> only 0x80 driven, SDA released from that point; done=1, nack_received=1, bytes_sent=1.
- Master ACKs the final byte of NUM_BYTES=1 (0xFF) -> SDA_down stays 0 for the following 8 SCL clocks, done=1, bytes_sent=1.
- STOP generated by the master during the ACK slot of byte 0 -> aborted=1, done=1, SDA_down=0 within one cycle.
- enable dropped after bit 4 of 0x00 (SDA_down=1) -> SDA_down=0 the next cycle, state IDLE, done=0. rst asserted mid-byte -> all outputs 0 immediately.
- Timing check for every transfer: no SDA_down transition while SCL=1, and every transition occurs exactly one FPGA_clk after an SCL fall.
